// File: rtl/noc_traffic_gen_if.sv
// Node-to-network lane: packet data with its valid flag, plus the network's
// per-node enable coming back the other way.
interface noc_traffic_gen_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] o_data;
  logic              o_data_val;
  logic              i_en;

  modport master (output o_data, output o_data_val, input i_en);
  modport slave  (input o_data, input o_data_val, output i_en);
endinterface

// File: rtl/noc_traffic_gen.sv
// Per-node packet source: paced generation of LFSR packets into a small FIFO
// that drains into one network input lane under the network's enable.
module noc_traffic_gen #(
  parameter int          NODES      = 16,
  parameter int          NODE_ID    = 0,
  parameter int          ID_W       = 4,
  parameter int          SEQ_W      = 8,
  parameter int          PAY_W      = 16,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_start,
  input  logic [7:0]        i_inj_period,
  input  logic [15:0]       i_pkt_limit,
  noc_traffic_gen_if.master net,
  output logic [15:0]       o_sent_cnt,
  output logic [15:0]       o_stall_cnt,
  output logic              o_busy,
  output logic              o_done
);
  localparam int DATA_W = 2*ID_W + SEQ_W + PAY_W;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam logic [ID_W-1:0] SELF_ID = ID_W'(NODE_ID % NODES);
  localparam logic [ID_W-1:0] ALT_ID  = ID_W'((NODE_ID ^ 1) % NODES);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state;
  logic [7:0]        period_q;
  logic [15:0]       limit_q;
  logic [15:0]       gen_cnt;
  logic [7:0]        timer;
  logic [SEQ_W-1:0]  seq;
  logic [15:0]       lfsr;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;

  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;
  logic              push;
  logic              stall;
  logic              period_hit;
  logic              attempt;
  logic              start_ok;
  logic              lfsr_fb;
  logic [ID_W-1:0]   dest_raw;
  logic [ID_W-1:0]   dest;
  logic [DATA_W-1:0] pkt;

  assign fifo_full  = (count == (PTR_W+1)'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);
  assign pop        = !fifo_empty && net.i_en;

  // Periods 0 and 1 both mean an attempt every cycle.
  assign period_hit = (period_q <= 8'd1) || (timer == period_q - 8'd1);
  assign attempt    = (state == S_RUN) && (gen_cnt != limit_q) && period_hit;

  // A simultaneous pop frees a slot, so a full FIFO can still accept a push.
  assign push       = attempt && (!fifo_full || pop);
  assign stall      = attempt && fifo_full && !pop;
  assign start_ok   = i_start && ((state == S_IDLE) || (state == S_DONE));

  assign lfsr_fb    = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];
  assign dest_raw   = lfsr[ID_W-1:0];
  assign dest       = (dest_raw == SELF_ID) ? ALT_ID : dest_raw;
  assign pkt        = {dest, SELF_ID, seq, lfsr[PAY_W-1:0]};

  assign net.o_data_val = !fifo_empty;
  assign net.o_data     = fifo_empty ? '0 : mem[rd_ptr];
  assign o_busy         = (state == S_RUN) || (state == S_DRAIN);
  assign o_done         = (state == S_DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      period_q    <= '0;
      limit_q     <= '0;
      gen_cnt     <= '0;
      timer       <= '0;
      seq         <= '0;
      lfsr        <= LFSR_SEED;
      o_sent_cnt  <= '0;
      o_stall_cnt <= '0;
    end else begin
      if (pop) o_sent_cnt <= o_sent_cnt + 16'd1;
      case (state)
        S_IDLE, S_DONE: begin
          if (start_ok) begin
            state       <= S_RUN;
            period_q    <= i_inj_period;
            limit_q     <= i_pkt_limit;
            gen_cnt     <= '0;
            timer       <= '0;
            seq         <= '0;
            o_sent_cnt  <= '0;
            o_stall_cnt <= '0;
          end
        end
        S_RUN: begin
          timer <= period_hit ? 8'd0 : timer + 8'd1;
          if (gen_cnt == limit_q) state <= S_DRAIN;
          if (push) begin
            gen_cnt <= gen_cnt + 16'd1;
            seq     <= seq + SEQ_W'(1);
            lfsr    <= {lfsr_fb, lfsr[15:1]};
          end
          if (stall && (o_stall_cnt != 16'hFFFF)) o_stall_cnt <= o_stall_cnt + 16'd1;
        end
        S_DRAIN: begin
          if (fifo_empty) state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= pkt;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule
